// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - shared types and encodings for the multicycle control unit (MC_CTRL_ADDI_EN adds ADDI)
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE   = 4'd6,
        S_ALU_WB    = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9
`ifdef MC_CTRL_ADDI_EN
        ,
        S_IMM_EXEC  = 4'd10,
        S_IMM_WB    = 4'd11
`endif
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_SHIMM  = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       memto_reg;
        logic       ir_write;
        logic       reg_write;
        logic       reg_dst;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

    function automatic logic opcode_known(input logic [5:0] op);
        logic known;
        known = (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
                (op == OP_BEQ) || (op == OP_J);
`ifdef MC_CTRL_ADDI_EN
        known = known || (op == OP_ADDI);
`endif
        return known;
    endfunction

endpackage

// File: rtl/mc_ctrl_outdec.sv
// rtl/mc_ctrl_outdec.sv - state to datapath control decode (MC_CTRL_ADDI_EN adds IMM states)
module mc_ctrl_outdec
    import mc_ctrl_pkg::*;
(
    input  state_t state,
    input  logic   mem_ready,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                // IR load and PC+4 only commit once memory returns the word
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_SHIMM;
            end
            S_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_MEM_READ: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            S_MEM_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.memto_reg = 1'b1;
            end
            S_MEM_WRITE: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
            end
            S_EXECUTE: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_ALU_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
`ifdef MC_CTRL_ADDI_EN
            S_IMM_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_IMM_WB: begin
                ctrl.reg_write = 1'b1;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_control_unit.sv
// rtl/mc_control_unit.sv - multicycle CPU control FSM with retired-instruction counter (MC_CTRL_ADDI_EN adds ADDI)
module mc_control_unit
    import mc_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             MemtoReg,
    output logic             IRWrite,
    output logic             RegWrite,
    output logic             RegDst,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       PCSource,
    output logic [3:0]       state,
    output logic             illegal_op,
    output logic [CNT_W-1:0] instr_count
);

    state_t cur;
    ctrl_t  ctrl;
    logic   retire;

    always_comb begin
        retire = 1'b0;
        case (cur)
            S_MEM_WB, S_ALU_WB, S_BRANCH, S_JUMP: retire = 1'b1;
            S_MEM_WRITE:                          retire = mem_ready;
`ifdef MC_CTRL_ADDI_EN
            S_IMM_WB:                             retire = 1'b1;
`endif
            default:                              retire = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur         <= S_FETCH;
            instr_count <= '0;
        end else begin
            case (cur)
                S_FETCH:     if (mem_ready) cur <= S_DECODE;
                S_DECODE: begin
                    case (opcode)
                        OP_LW, OP_SW: cur <= S_MEM_ADDR;
                        OP_RTYPE:     cur <= S_EXECUTE;
                        OP_BEQ:       cur <= S_BRANCH;
                        OP_J:         cur <= S_JUMP;
`ifdef MC_CTRL_ADDI_EN
                        OP_ADDI:      cur <= S_IMM_EXEC;
`endif
                        default:      cur <= S_FETCH;
                    endcase
                end
                S_MEM_ADDR:  cur <= (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
                S_MEM_READ:  if (mem_ready) cur <= S_MEM_WB;
                S_MEM_WRITE: if (mem_ready) cur <= S_FETCH;
                S_EXECUTE:   cur <= S_ALU_WB;
`ifdef MC_CTRL_ADDI_EN
                S_IMM_EXEC:  cur <= S_IMM_WB;
`endif
                default:     cur <= S_FETCH;
            endcase
            if (retire) instr_count <= instr_count + CNT_W'(1);
        end
    end

    mc_ctrl_outdec u_outdec (
        .state     (cur),
        .mem_ready (mem_ready),
        .ctrl      (ctrl)
    );

    // Write strobes are qualified by reset so an abort mid-instruction cannot leak a write
    assign PCWrite     = ctrl.pc_write      & reset;
    assign PCWriteCond = ctrl.pc_write_cond & reset;
    assign MemWrite    = ctrl.mem_write     & reset;
    assign IRWrite     = ctrl.ir_write      & reset;
    assign RegWrite    = ctrl.reg_write     & reset;
    assign IorD        = ctrl.iord;
    assign MemRead     = ctrl.mem_read;
    assign MemtoReg    = ctrl.memto_reg;
    assign RegDst      = ctrl.reg_dst;
    assign ALUSrcA     = ctrl.alu_src_a;
    assign ALUSrcB     = ctrl.alu_src_b;
    assign ALUOp       = ctrl.alu_op;
    assign PCSource    = ctrl.pc_source;
    assign state       = cur;
    assign illegal_op  = reset && (cur == S_DECODE) && !opcode_known(opcode);

endmodule

// File: tb/tb_mc_control_unit.sv
// tb/tb_mc_control_unit.sv - self-checking bench for mc_control_unit (MC_CTRL_ADDI_EN selects ADDI expectations)
module tb_mc_control_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  opcode;
    logic        mem_ready;
    logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
    logic        IRWrite, RegWrite, RegDst, ALUSrcA, illegal_op;
    logic [1:0]  ALUSrcB, ALUOp, PCSource;
    logic [3:0]  state;
    logic [31:0] instr_count;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_count = 0;

    mc_control_unit #(.CNT_W(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .opcode      (opcode),
        .mem_ready   (mem_ready),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .MemtoReg    (MemtoReg),
        .IRWrite     (IRWrite),
        .RegWrite    (RegWrite),
        .RegDst      (RegDst),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .ALUOp       (ALUOp),
        .PCSource    (PCSource),
        .state       (state),
        .illegal_op  (illegal_op),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected state walk of one instruction when memory never stalls
    function automatic void instr_path(input logic [5:0] op, output int p[$], output bit illegal);
        illegal = 1'b0;
        case (op)
            6'b000000: p = '{0, 1, 6, 7};
            6'b100011: p = '{0, 1, 2, 3, 4};
            6'b101011: p = '{0, 1, 2, 5};
            6'b000100: p = '{0, 1, 8};
            6'b000010: p = '{0, 1, 9};
`ifdef MC_CTRL_ADDI_EN
            6'b001000: p = '{0, 1, 10, 11};
`endif
            default: begin p = '{0, 1}; illegal = 1'b1; end
        endcase
    endfunction

    function automatic bit in_set(input int s, input int set[$]);
        foreach (set[i]) if (set[i] == s) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check_cycle(input int st, input bit illegal);
        int pcs, aop, srcb;
        pcs  = (st == 8) ? 1 : (st == 9) ? 2 : 0;
        aop  = (st == 6) ? 2 : (st == 8) ? 1 : 0;
        srcb = (st == 0) ? 1 : (st == 1) ? 3 : in_set(st, '{2, 10}) ? 2 : 0;
        check("state",       32'(state),       32'(st));
        check("instr_count", instr_count,      model_count);
        check("illegal_op",  32'(illegal_op),  32'(st == 1 && illegal));
        check("RegWrite",    32'(RegWrite),    32'(in_set(st, '{4, 7, 11})));
        check("RegDst",      32'(RegDst),      32'(st == 7));
        check("MemtoReg",    32'(MemtoReg),    32'(st == 4));
        check("MemWrite",    32'(MemWrite),    32'(st == 5));
        check("MemRead",     32'(MemRead),     32'(st == 0 || st == 3));
        check("IorD",        32'(IorD),        32'(st == 3 || st == 5));
        check("IRWrite",     32'(IRWrite),     32'(st == 0 && mem_ready));
        check("PCWrite",     32'(PCWrite),     32'((st == 0 && mem_ready) || st == 9));
        check("PCWriteCond", 32'(PCWriteCond), 32'(st == 8));
        check("ALUSrcA",     32'(ALUSrcA),     32'(in_set(st, '{2, 6, 8, 10})));
        check("ALUSrcB",     32'(ALUSrcB),     32'(srcb));
        check("ALUOp",       32'(ALUOp),       32'(aop));
        check("PCSource",    32'(PCSource),    32'(pcs));
    endtask

    // Inputs change 1 time unit after posedge; outputs sampled at negedge
    task automatic run_instr(input logic [5:0] op, input int stall_fetch, input int stall_mem);
        int  p[$];
        bit  illegal;
        int  stalls;
        instr_path(op, p, illegal);
        opcode = op;
        foreach (p[i]) begin
            stalls = (p[i] == 0) ? stall_fetch : (p[i] == 3 || p[i] == 5) ? stall_mem : 0;
            for (int k = 0; k <= stalls; k++) begin
                mem_ready = (k < stalls) ? 1'b0 : 1'b1;
                @(negedge clk);
                check_cycle(p[i], illegal);
                @(posedge clk);
                #1;
            end
            if (i == p.size() - 1 && !illegal) model_count++;
        end
    endtask

    initial begin
        logic [5:0] ops [7];
        logic [5:0] op;
        ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000, 6'b111111};

        reset     = 1'b0;
        mem_ready = 1'b1;
        opcode    = 6'b000000;
        repeat (4) begin
            @(negedge clk);
            check("rst_state",    32'(state),    32'd0);
            check("rst_count",    instr_count,   32'd0);
            check("rst_IRWrite",  32'(IRWrite),  32'd0);
            check("rst_PCWrite",  32'(PCWrite),  32'd0);
            check("rst_MemRead",  32'(MemRead),  32'd1);
            check("rst_ALUSrcB",  32'(ALUSrcB),  32'd1);
            check("rst_illegal",  32'(illegal_op), 32'd0);
        end
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("rel_state",   32'(state),   32'd0);
        check("rel_IRWrite", 32'(IRWrite), 32'd1);
        check("rel_count",   instr_count,  32'd0);
        @(posedge clk);
        #1;
        // first edge after release consumed by FETCH with mem_ready=1, now in DECODE
        check("rel_decode", 32'(state), 32'd1);
        reset = 1'b0;
        #1 reset = 1'b1;

        run_instr(6'b000000, 0, 0);
        run_instr(6'b100011, 0, 2);
        run_instr(6'b000100, 0, 0);
        run_instr(6'b000010, 0, 0);
        run_instr(6'b111111, 0, 0);
        run_instr(6'b001000, 0, 0);
        run_instr(6'b101011, 1, 1);

        for (int n = 0; n < 60; n++) begin
            op = ($urandom_range(0, 7) == 7) ? 6'($urandom) : ops[$urandom_range(0, 6)];
            run_instr(op, $urandom_range(0, 2), $urandom_range(0, 3));
        end

        // Abort a store while memory is stalling
        opcode = 6'b101011;
        mem_ready = 1'b1;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            check_cycle((s == 2) ? 2 : s, 1'b0);
            @(posedge clk);
            #1;
        end
        mem_ready = 1'b0;
        @(negedge clk);
        check("abort_pre_MemWrite", 32'(MemWrite), 32'd1);
        #2 reset = 1'b0;
        #1;
        model_count = 0;
        check("abort_MemWrite", 32'(MemWrite), 32'd0);
        check("abort_state",    32'(state),    32'd0);
        check("abort_count",    instr_count,   32'd0);
        check("abort_IRWrite",  32'(IRWrite),  32'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        run_instr(6'b000000, 0, 0);
        run_instr(6'b101011, 0, 0);
        @(negedge clk);
        check("final_count", instr_count, 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
